// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: frame sequencer for the UART transmitter.
// Accepts a byte on a valid/ack handshake and loads it into the serializer.
// Steps the line through START, DATA, optional PARITY and STOP1/STOP2, one bit per baud tick.
// Every output is registered except ser_en, which is state & tick.
module uart_tx_ctrl #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              Data_valid,
    input  logic [DATA_W-1:0] P_data,
    input  logic              PAR_EN,
    input  logic              PAR_TYP,
    input  logic              tick,
    input  logic              ser_done,
    output logic              ser_load,
    output logic [DATA_W-1:0] ser_pdata,
    output logic              ser_en,
    output logic [1:0]        mux_sel,
    output logic              par_bit,
    output logic              busy,
    output logic              tx_ack,
    output logic              err
);

    // Sequencer states
    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StLoad   = 3'd1;
    localparam logic [2:0] StStart  = 3'd2;
    localparam logic [2:0] StData   = 3'd3;
    localparam logic [2:0] StParity = 3'd4;
    localparam logic [2:0] StStop1  = 3'd5;
    localparam logic [2:0] StStop2  = 3'd6;

    // Output-mux line selects
    localparam logic [1:0] MuxStart  = 2'b00;
    localparam logic [1:0] MuxData   = 2'b01;
    localparam logic [1:0] MuxParity = 2'b10;
    localparam logic [1:0] MuxIdle   = 2'b11;

    // Tick count already seen in DATA when the DATA_W-th tick arrives
    localparam logic [3:0] WdLast = 4'(DATA_W - 1);

    logic [2:0]        state_q, state_d;
    logic [3:0]        tick_cnt_q, tick_cnt_d;
    logic [DATA_W-1:0] pdata_q, pdata_d;
    logic              par_en_q, par_en_d;
    logic              par_bit_q, par_bit_d;
    logic              ser_load_q, ser_load_d;
    logic              tx_ack_q, tx_ack_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;
    logic [1:0]        mux_q, mux_d;
    logic [2:0]        frame_end_state;

    // A request on the ending tick chains straight into the next LOAD
    assign frame_end_state = Data_valid ? StLoad : StIdle;

    // Next-state, latch and registered-output decode
    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        pdata_d    = pdata_q;
        par_en_d   = par_en_q;
        par_bit_d  = par_bit_q;
        ser_load_d = 1'b0;
        tx_ack_d   = 1'b0;
        err_d      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (Data_valid) begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                state_d = StStart;
            end
            StStart: begin
                if (tick) begin
                    state_d    = StData;
                    tick_cnt_d = '0;
                end
            end
            StData: begin
                if (tick) begin
                    tick_cnt_d = tick_cnt_q + 4'd1;
                    if (ser_done) begin
                        state_d = par_en_q ? StParity : StStop1;
                    end else if (tick_cnt_q == WdLast) begin
                        // Serializer never signalled its last bit: abandon data, skip parity
                        state_d = StStop1;
                        err_d   = 1'b1;
                    end
                end
            end
            StParity: begin
                if (tick) begin
                    state_d = StStop1;
                end
            end
            StStop1: begin
                if (tick) begin
                    state_d = (STOP_BITS == 2) ? StStop2 : frame_end_state;
                end
            end
            StStop2: begin
                if (tick) begin
                    state_d = frame_end_state;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Entering LOAD: capture the byte and its parity so later host changes are harmless
        if (state_d == StLoad) begin
            ser_load_d = 1'b1;
            tx_ack_d   = 1'b1;
            pdata_d    = P_data;
            par_en_d   = PAR_EN;
            par_bit_d  = (^P_data) ^ PAR_TYP;
        end

        busy_d = (state_d != StIdle);

        unique case (state_d)
            StStart:  mux_d = MuxStart;
            StData:   mux_d = MuxData;
            StParity: mux_d = MuxParity;
            default:  mux_d = MuxIdle;
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            tick_cnt_q <= '0;
            pdata_q    <= '0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            ser_load_q <= 1'b0;
            tx_ack_q   <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            mux_q      <= MuxIdle;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            pdata_q    <= pdata_d;
            par_en_q   <= par_en_d;
            par_bit_q  <= par_bit_d;
            ser_load_q <= ser_load_d;
            tx_ack_q   <= tx_ack_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
            mux_q      <= mux_d;
        end
    end

    assign ser_en    = (state_q == StData) & tick;
    assign ser_load  = ser_load_q;
    assign ser_pdata = pdata_q;
    assign mux_sel   = mux_q;
    assign par_bit   = par_bit_q;
    assign busy      = busy_q;
    assign tx_ack    = tx_ack_q;
    assign err       = err_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb_uart_tx_ctrl: randomized self-checking bench for uart_tx_ctrl.
// Instance 0 uses one stop bit and instance 1 uses two.
// A behavioural serializer feeds ser_done. The line bit is captured on every baud tick and compared
// against frames built directly from the byte and its parity settings.
module tb_uart_tx_ctrl;

    localparam int DW = 8;
    localparam int HIST = 1024;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tick = 1'b0;
    logic [DW-1:0] p_data = '0;
    logic par_en = 1'b0;
    logic par_typ = 1'b0;
    logic dv [2];
    bit   done_en = 1'b1;

    logic          ser_done  [2];
    logic          ser_load  [2];
    logic [DW-1:0] ser_pdata [2];
    logic          ser_en    [2];
    logic [1:0]    mux_sel   [2];
    logic          par_bit   [2];
    logic          busy      [2];
    logic          tx_ack    [2];
    logic          err       [2];

    // Behavioural serializer state
    logic [DW-1:0] sh     [2];
    int            sh_cnt [2] = '{0, 0};

    // Monitor history and counters
    logic       line_hist [2][HIST];
    logic [1:0] mux_hist  [2][HIST];
    int         line_n   [2] = '{0, 0};
    int         sen_cnt  [2] = '{0, 0};
    int         ack_cnt  [2] = '{0, 0};
    int         err_cnt  [2] = '{0, 0};
    int         idle_cnt [2] = '{0, 0};
    logic [1:0] err_mux  [2];

    logic       exp_q  [$];
    logic [1:0] expm_q [$];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    uart_tx_ctrl #(.DATA_W(DW), .STOP_BITS(1)) u_dut0 (
        .clk(clk), .rst(rst), .Data_valid(dv[0]), .P_data(p_data), .PAR_EN(par_en),
        .PAR_TYP(par_typ), .tick(tick), .ser_done(ser_done[0]), .ser_load(ser_load[0]),
        .ser_pdata(ser_pdata[0]), .ser_en(ser_en[0]), .mux_sel(mux_sel[0]),
        .par_bit(par_bit[0]), .busy(busy[0]), .tx_ack(tx_ack[0]), .err(err[0])
    );

    uart_tx_ctrl #(.DATA_W(DW), .STOP_BITS(2)) u_dut1 (
        .clk(clk), .rst(rst), .Data_valid(dv[1]), .P_data(p_data), .PAR_EN(par_en),
        .PAR_TYP(par_typ), .tick(tick), .ser_done(ser_done[1]), .ser_load(ser_load[1]),
        .ser_pdata(ser_pdata[1]), .ser_en(ser_en[1]), .mux_sel(mux_sel[1]),
        .par_bit(par_bit[1]), .busy(busy[1]), .tx_ack(tx_ack[1]), .err(err[1])
    );

    assign ser_done[0] = done_en && (sh_cnt[0] == DW - 1);
    assign ser_done[1] = done_en && (sh_cnt[1] == DW - 1);

    // Serializer model: load presents bit0, each enable shifts the next bit out
    always @(posedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (ser_load[g]) begin
                sh[g]     <= ser_pdata[g];
                sh_cnt[g] <= 0;
            end else if (ser_en[g]) begin
                sh[g]     <= sh[g] >> 1;
                sh_cnt[g] <= sh_cnt[g] + 1;
            end
        end
    end

    // Line monitor: the bit on the line when a tick arrives is the bit that tick completes
    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (tick && busy[g] && !ser_load[g]) begin
                if (line_n[g] < HIST) begin
                    case (mux_sel[g])
                        2'b00:   line_hist[g][line_n[g]] <= 1'b0;
                        2'b01:   line_hist[g][line_n[g]] <= sh[g][0];
                        2'b10:   line_hist[g][line_n[g]] <= par_bit[g];
                        default: line_hist[g][line_n[g]] <= 1'b1;
                    endcase
                    mux_hist[g][line_n[g]] <= mux_sel[g];
                end
                line_n[g] <= line_n[g] + 1;
            end
            if (ser_en[g]) sen_cnt[g] <= sen_cnt[g] + 1;
            if (tx_ack[g]) ack_cnt[g] <= ack_cnt[g] + 1;
            if (err[g]) begin
                err_cnt[g] <= err_cnt[g] + 1;
                err_mux[g] <= mux_sel[g];
            end
            if (!busy[g]) idle_cnt[g] <= idle_cnt[g] + 1;
        end
    end

    // Baud tick every fourth clock
    initial begin
        int ph;
        ph = 0;
        forever begin
            @(posedge clk);
            #1;
            tick = (ph == 3);
            ph = (ph + 1) % 4;
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not reach its summary");
        $fatal(1, "timeout");
    end

    function automatic logic parity_of(input logic [DW-1:0] data, input logic ptyp);
        int ones;
        ones = $countones(data);
        // even: parity bit makes the ones count even; odd: makes it odd
        return ptyp ? ((ones % 2) == 0) : ((ones % 2) == 1);
    endfunction

    // Append the expected line bits and line selects of one frame
    task automatic push_frame(input logic [DW-1:0] data, input logic pen, input logic ptyp,
                              input int stops, input bit wd);
        exp_q.push_back(1'b0);
        expm_q.push_back(2'b00);
        for (int i = 0; i < DW; i++) begin
            exp_q.push_back(data[i]);
            expm_q.push_back(2'b01);
        end
        if (pen && !wd) begin
            exp_q.push_back(parity_of(data, ptyp));
            expm_q.push_back(2'b10);
        end
        for (int s = 0; s < stops; s++) begin
            exp_q.push_back(1'b1);
            expm_q.push_back(2'b11);
        end
    endtask

    task automatic wait_idle(input int g);
        int n;
        n = 0;
        while (busy[g] === 1'b1 && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        dv[0] = 1'b0;
        dv[1] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int g = 0; g < 2; g++) begin
            checks++;
            if (mux_sel[g] !== 2'b11) begin
                failures++;
                $display("FAIL reset_mux[%0d]: got %b required 11", g, mux_sel[g]);
            end
            checks++;
            if (busy[g] !== 1'b0 || ser_en[g] !== 1'b0) begin
                failures++;
                $display("FAIL reset_busy[%0d]: busy=%b ser_en=%b required 0 0", g, busy[g],
                         ser_en[g]);
            end
            checks++;
            if (ser_load[g] !== 1'b0 || tx_ack[g] !== 1'b0 || err[g] !== 1'b0) begin
                failures++;
                $display("FAIL reset_pulses[%0d]: load=%b ack=%b err=%b required 0 0 0", g,
                         ser_load[g], tx_ack[g], err[g]);
            end
            checks++;
            if (par_bit[g] !== 1'b0 || ser_pdata[g] !== '0) begin
                failures++;
                $display("FAIL reset_latch[%0d]: par_bit=%b pdata=%h required 0 00", g,
                         par_bit[g], ser_pdata[g]);
            end
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // One complete frame on instance g, checked end to end
    task automatic test_frame(input int g, input logic [DW-1:0] data, input logic pen,
                              input logic ptyp);
        int base, sen0, ack0, mism, nexp, idx;
        logic exp_par;
        exp_par = parity_of(data, ptyp);
        exp_q.delete();
        expm_q.delete();
        push_frame(data, pen, ptyp, g + 1, 1'b0);
        nexp = exp_q.size();
        base = line_n[g];
        sen0 = sen_cnt[g];
        ack0 = ack_cnt[g];
        @(posedge clk);
        #1;
        p_data = data;
        par_en = pen;
        par_typ = ptyp;
        dv[g] = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (tx_ack[g] !== 1'b1 || ser_load[g] !== 1'b1 || busy[g] !== 1'b1) begin
            failures++;
            $display("FAIL ack_latency[%0d]: ack=%b load=%b busy=%b required 1 1 1", g,
                     tx_ack[g], ser_load[g], busy[g]);
        end
        checks++;
        if (ser_pdata[g] !== data || par_bit[g] !== exp_par) begin
            failures++;
            $display("FAIL latch[%0d]: pdata=%h par_bit=%b required %h %b", g, ser_pdata[g],
                     par_bit[g], data, exp_par);
        end
        dv[g] = 1'b0;
        // Scramble host inputs: the frame in flight must not notice
        p_data = DW'($urandom);
        par_en = 1'($urandom);
        par_typ = 1'($urandom);
        @(posedge clk);
        #1;
        checks++;
        if (tx_ack[g] !== 1'b0 || mux_sel[g] !== 2'b00) begin
            failures++;
            $display("FAIL start_phase[%0d]: ack=%b mux=%b required 0 00", g, tx_ack[g],
                     mux_sel[g]);
        end
        wait_idle(g);
        checks++;
        if (busy[g] !== 1'b0) begin
            failures++;
            $display("FAIL frame_timeout[%0d]: busy=%b required 0", g, busy[g]);
        end
        checks++;
        if (line_n[g] - base != nexp) begin
            failures++;
            $display("FAIL frame_len[%0d]: got %0d ticks required %0d", g, line_n[g] - base,
                     nexp);
        end
        mism = 0;
        for (int i = 0; i < nexp; i++) begin
            idx = base + i;
            if (idx < HIST && (line_hist[g][idx] !== exp_q[i] || mux_hist[g][idx] !== expm_q[i]))
                mism++;
        end
        checks++;
        if (mism != 0) begin
            failures++;
            $display("FAIL frame_bits[%0d] data=%h pen=%b typ=%b: got %0d bad bits required 0",
                     g, data, pen, ptyp, mism);
        end
        checks++;
        if (sen_cnt[g] - sen0 != DW || ack_cnt[g] - ack0 != 1) begin
            failures++;
            $display("FAIL frame_pulses[%0d]: ser_en=%0d acks=%0d required %0d 1", g,
                     sen_cnt[g] - sen0, ack_cnt[g] - ack0, DW);
        end
    endtask

    task automatic test_parity();
        test_frame(0, 8'hA5, 1'b1, 1'b0);
        test_frame(0, 8'h01, 1'b1, 1'b1);
        test_frame(0, 8'h01, 1'b0, 1'b1);
        for (int r = 0; r < 3; r++) begin
            test_frame(0, DW'($urandom), 1'($urandom), 1'($urandom));
            test_frame(1, DW'($urandom), 1'($urandom), 1'($urandom));
        end
    endtask

    task automatic test_stop2();
        test_frame(1, 8'hFF, 1'b0, 1'b0);
        test_frame(1, 8'h3C, 1'b1, 1'b1);
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] d1, d2;
        logic pen, ptyp;
        int base, ack0, idle0, n, mism, nexp, idx;
        d1 = DW'($urandom);
        d2 = DW'($urandom);
        pen = 1'($urandom);
        ptyp = 1'($urandom);
        exp_q.delete();
        expm_q.delete();
        push_frame(d1, pen, ptyp, 1, 1'b0);
        push_frame(d2, pen, ptyp, 1, 1'b0);
        nexp = exp_q.size();
        base = line_n[0];
        ack0 = ack_cnt[0];
        @(posedge clk);
        #1;
        p_data = d1;
        par_en = pen;
        par_typ = ptyp;
        dv[0] = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (tx_ack[0] !== 1'b1) begin
            failures++;
            $display("FAIL b2b_first_ack: got %b required 1", tx_ack[0]);
        end
        p_data = d2;
        idle0 = idle_cnt[0];
        @(posedge clk);
        #1;
        n = 0;
        while (tx_ack[0] !== 1'b1 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        dv[0] = 1'b0;
        checks++;
        if (tx_ack[0] !== 1'b1 || idle_cnt[0] != idle0) begin
            failures++;
            $display("FAIL b2b_second_ack: ack=%b idle_cycles=%0d required 1 0", tx_ack[0],
                     idle_cnt[0] - idle0);
        end
        // A stray request during DATA must be ignored
        n = 0;
        while (mux_sel[0] !== 2'b01 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        p_data = DW'($urandom);
        dv[0] = 1'b1;
        @(posedge clk);
        #1;
        dv[0] = 1'b0;
        wait_idle(0);
        checks++;
        if (ack_cnt[0] - ack0 != 2) begin
            failures++;
            $display("FAIL b2b_ack_count: got %0d required 2", ack_cnt[0] - ack0);
        end
        checks++;
        if (line_n[0] - base != nexp) begin
            failures++;
            $display("FAIL b2b_len: got %0d ticks required %0d", line_n[0] - base, nexp);
        end
        mism = 0;
        for (int i = 0; i < nexp; i++) begin
            idx = base + i;
            if (idx < HIST && (line_hist[0][idx] !== exp_q[i] || mux_hist[0][idx] !== expm_q[i]))
                mism++;
        end
        checks++;
        if (mism != 0) begin
            failures++;
            $display("FAIL b2b_bits: got %0d bad bits required 0", mism);
        end
    endtask

    task automatic test_watchdog();
        logic [DW-1:0] d;
        int base, err0, sen0, mism, nexp, idx;
        d = DW'($urandom);
        exp_q.delete();
        expm_q.delete();
        push_frame(d, 1'b1, 1'b0, 1, 1'b1);
        nexp = exp_q.size();
        base = line_n[0];
        err0 = err_cnt[0];
        sen0 = sen_cnt[0];
        done_en = 1'b0;
        @(posedge clk);
        #1;
        p_data = d;
        par_en = 1'b1;
        par_typ = 1'b0;
        dv[0] = 1'b1;
        @(posedge clk);
        #1;
        dv[0] = 1'b0;
        wait_idle(0);
        done_en = 1'b1;
        checks++;
        if (err_cnt[0] - err0 != 1 || err_mux[0] !== 2'b11) begin
            failures++;
            $display("FAIL watchdog_err: err_cycles=%0d mux=%b required 1 11",
                     err_cnt[0] - err0, err_mux[0]);
        end
        checks++;
        if (line_n[0] - base != nexp || sen_cnt[0] - sen0 != DW) begin
            failures++;
            $display("FAIL watchdog_len: ticks=%0d ser_en=%0d required %0d %0d",
                     line_n[0] - base, sen_cnt[0] - sen0, nexp, DW);
        end
        mism = 0;
        for (int i = 0; i < nexp; i++) begin
            idx = base + i;
            if (idx < HIST && (line_hist[0][idx] !== exp_q[i] || mux_hist[0][idx] !== expm_q[i]))
                mism++;
        end
        checks++;
        if (mism != 0) begin
            failures++;
            $display("FAIL watchdog_bits: got %0d bad bits required 0", mism);
        end
    endtask

    task automatic test_reset_mid();
        int n, ack0, err0;
        @(posedge clk);
        #1;
        p_data = DW'($urandom);
        par_en = 1'b1;
        par_typ = 1'($urandom);
        dv[0] = 1'b1;
        @(posedge clk);
        #1;
        dv[0] = 1'b0;
        n = 0;
        while (mux_sel[0] !== 2'b10 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (mux_sel[0] !== 2'b10) begin
            failures++;
            $display("FAIL midreset_reach_parity: mux=%b required 10", mux_sel[0]);
        end
        ack0 = ack_cnt[0];
        err0 = err_cnt[0];
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (mux_sel[0] !== 2'b11 || busy[0] !== 1'b0 || ser_pdata[0] !== '0) begin
            failures++;
            $display("FAIL midreset_state: mux=%b busy=%b pdata=%h required 11 0 00",
                     mux_sel[0], busy[0], ser_pdata[0]);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (ack_cnt[0] != ack0 || err_cnt[0] != err0) begin
            failures++;
            $display("FAIL midreset_pulses: acks=%0d errs=%0d required 0 0", ack_cnt[0] - ack0,
                     err_cnt[0] - err0);
        end
        test_frame(0, DW'($urandom), 1'b1, 1'($urandom));
    endtask

    initial begin
        dv[0] = 1'b0;
        dv[1] = 1'b0;
        test_reset();
        test_parity();
        test_stop2();
        test_back_to_back();
        test_watchdog();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
Frame sequencer for the UART transmitter. It accepts a byte on a valid/ack handshake, latches it with the parity configuration, and loads the serializer. It then steps the line through START, DATA, optional PARITY and STOP, paced by a baud tick. It drives the serializer shift enable, the output-mux select, the parity bit and the busy flag. It sits between the host interface and the serializer/output-mux datapath.

Parameters:
DATA_W, 8, data bits per frame; also the watchdog limit for DATA.
STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
clk  in  1  single clock; all logic on rising edge.
rst  in  1  synchronous, active-high reset.
Data_valid  in  1  host has a byte on P_data.
P_data  in  DATA_W  byte to transmit.
PAR_EN  in  1  1 = parity bit inserted.
PAR_TYP  in  1  0 = even, 1 = odd.
tick  in  1  one-clk baud enable; one line bit lasts one tick period.
ser_done  in  1  serializer flag, high while its last data bit is on the line.
ser_load  out  1  one-clk pulse; serializer latches ser_pdata and presents bit0.
ser_pdata  out  DATA_W  latched byte to the serializer.
ser_en  out  1  serializer shift enable.
mux_sel  out  2  line select: 00 = start (0), 01 = serializer data, 10 = parity, 11 = stop/idle (1).
par_bit  out  1  parity of the latched byte.
busy  out  1  frame in progress.
tx_ack  out  1  one-clk pulse; byte accepted.
err  out  1  one-clk pulse; DATA watchdog expired.

Behaviour:
- Reset values: state IDLE; ser_load=0; ser_en=0; tx_ack=0; err=0; busy=0; mux_sel=11; par_bit=0; ser_pdata=0; tick counter 0.
- Reset is synchronous. Asserting rst mid-frame aborts the frame at the next edge. The line returns to idle-high (mux_sel=11). No tx_ack and no err are produced.
- States: IDLE, LOAD, START, DATA, PARITY, STOP1, STOP2.
- IDLE: mux_sel=11, busy=0.
  - Data_valid=1 -> LOAD at the next edge.
  - tick is ignored.
- LOAD: lasts exactly 1 clk and is independent of tick.
  - ser_load=1, tx_ack=1, busy=1, mux_sel=11.
  - Latch P_data into ser_pdata; latch PAR_EN and PAR_TYP.
  - par_bit = XOR of the byte for even parity, XNOR for odd.
  - Next state START.
- START: mux_sel=00. On tick -> DATA.
- DATA: mux_sel=01; ser_en = tick; 4-bit tick counter increments on each tick.
  - On tick with ser_done=1 -> PARITY if the latched PAR_EN=1, else STOP1.
  - On the DATA_W-th tick with ser_done=0 -> STOP1 with err=1 for one clk. Parity is skipped.
- PARITY: mux_sel=10. On tick -> STOP1.
- STOP1: mux_sel=11. On tick:
  - STOP_BITS=2 -> STOP2.
  - Otherwise frame end.
- STOP2: mux_sel=11. On tick -> frame end.
- Frame end:
  - Data_valid=1 on the ending tick -> LOAD (back-to-back, busy stays 1).
  - Otherwise -> IDLE, busy=0 at the next edge.
- Latency: tx_ack and ser_load occur 1 clk after Data_valid is sampled in IDLE. START is on the line from that edge until the next tick.
- Frame length in ticks = 1 + DATA_W + PAR_EN + STOP_BITS.
- Data_valid while busy (except on the ending tick) is ignored: no ack and no latch. The host must hold Data_valid until it sees tx_ack.
- PAR_EN, PAR_TYP and P_data changes after LOAD have no effect on the current frame.
- The tick counter clears on entry to DATA.
- All outputs are registered except ser_en (combinational state & tick).

Test Plan:
1. Reset, then P_data=8'hA5, PAR_EN=1, PAR_TYP=0, pulse Data_valid, tick every 4 clk -> tx_ack 1 clk later. mux_sel sequence 00, 01 ×8 ticks, 10, 11. par_bit=0. busy high for 11 ticks. 8 ser_en pulses.
2. P_data=8'h01, PAR_EN=1, PAR_TYP=1 -> par_bit=0. Repeat with PAR_EN=0 -> no 10 phase; frame of 10 ticks.
3. STOP_BITS=2, P_data=8'hFF, PAR_EN=0 -> two stop ticks; busy drops after tick 11.
4. Data_valid held high across two frames -> second LOAD directly after the final stop tick with no IDLE cycle. Two tx_ack pulses. Data_valid pulsed during DATA -> no ack.
5. ser_done held 0 -> after the 8th DATA tick, err=1 for 1 clk and the next state is STOP1 (mux_sel=11).
6. rst=1 asserted during PARITY -> at the next edge state IDLE, mux_sel=11, busy=0. A new Data_valid after release is accepted normally.
